// File: rtl/count_sched_if.sv
// Request/grant bundle between the two requesters and the counter sequencer.
// Pure wiring: no latency; requesters hold req level-high as their only backpressure.
// master = requester side, slave = count_sched.
interface count_sched_if #(
  parameter int WIDTH = 8
);
  logic             req_a;
  logic             req_b;
  logic [WIDTH-1:0] len_a;
  logic [WIDTH-1:0] len_b;
  logic             gnt_a;
  logic             gnt_b;
  logic             busy;
  logic [WIDTH-1:0] cnt;
  logic             done_a;
  logic             done_b;

  modport master (
    output req_a, req_b, len_a, len_b,
    input  gnt_a, gnt_b, busy, cnt, done_a, done_b
  );

  modport slave (
    input  req_a, req_b, len_a, len_b,
    output gnt_a, gnt_b, busy, cnt, done_a, done_b
  );
endinterface

// File: rtl/count_sched.sv
// Two-requester counter sequencer; round-robin ties, or A-first when COUNT_SCHED_FIXED_PRIO_EN is defined.
// Latency: grant one edge after req is sampled in IDLE, L grant cycles, then a one-cycle done pulse.
// Backpressure: requests are level-held only; a req raised during RUN/DONE waits, dropping it mid-job aborts.
module count_sched #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  count_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Requester encoding for owner/last: 0 = A, 1 = B.
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] len_q, len_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             gnt_a_q, gnt_a_d;
  logic             gnt_b_q, gnt_b_d;
  logic             done_a_q, done_a_d;
  logic             done_b_q, done_b_d;
  logic             busy_q, busy_d;

  logic             any_req;
  logic             tie_to_b;
  logic             pick_b;
  logic [WIDTH-1:0] win_len;
  logic             owner_req;
  logic             at_last;

  always_comb begin
    any_req = bus.req_a | bus.req_b;
`ifdef COUNT_SCHED_FIXED_PRIO_EN
    tie_to_b = 1'b0;
`else
    tie_to_b = (last_q == SEL_A);
`endif
    pick_b    = bus.req_b & (~bus.req_a | tie_to_b);
    win_len   = pick_b ? bus.len_b : bus.len_a;
    owner_req = (owner_q == SEL_B) ? bus.req_b : bus.req_a;
    at_last   = (cnt_q == (len_q - WIDTH'(1)));
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    gnt_a_d  = gnt_a_q;
    gnt_b_d  = gnt_b_q;
    done_a_d = 1'b0;
    done_b_d = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        gnt_a_d = 1'b0;
        gnt_b_d = 1'b0;
        if (any_req) begin
          owner_d = pick_b;
          len_d   = win_len;
          if (win_len != '0) begin
            state_d = RUN;
            gnt_a_d = ~pick_b;
            gnt_b_d = pick_b;
          end else begin
            // Zero-length job completes without ever granting the counter.
            state_d  = DONE;
            done_a_d = ~pick_b;
            done_b_d = pick_b;
          end
        end
      end

      RUN: begin
        if (!owner_req) begin
          state_d = IDLE;
          gnt_a_d = 1'b0;
          gnt_b_d = 1'b0;
          cnt_d   = '0;
          last_d  = owner_q;
        end else if (at_last) begin
          // cnt keeps its final value through the DONE cycle.
          state_d  = DONE;
          gnt_a_d  = 1'b0;
          gnt_b_d  = 1'b0;
          done_a_d = (owner_q == SEL_A);
          done_b_d = (owner_q == SEL_B);
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
        gnt_a_d = 1'b0;
        gnt_b_d = 1'b0;
        cnt_d   = '0;
        last_d  = owner_q;
      end

      default: begin
        state_d = IDLE;
        gnt_a_d = 1'b0;
        gnt_b_d = 1'b0;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= SEL_A;
      last_q   <= SEL_B;
      len_q    <= '0;
      cnt_q    <= '0;
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
      done_a_q <= 1'b0;
      done_b_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      gnt_a_q  <= gnt_a_d;
      gnt_b_q  <= gnt_b_d;
      done_a_q <= done_a_d;
      done_b_q <= done_b_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.gnt_a  = gnt_a_q;
  assign bus.gnt_b  = gnt_b_q;
  assign bus.busy   = busy_q;
  assign bus.cnt    = cnt_q;
  assign bus.done_a = done_a_q;
  assign bus.done_b = done_b_q;

  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) !(gnt_a_q && gnt_b_q));
  a_done_onehot: assert property (@(posedge clk) disable iff (rst) !(done_a_q && done_b_q));
  a_done_pulse: assert property (@(posedge clk) disable iff (rst)
    (done_a_q || done_b_q) |=> !(done_a_q || done_b_q));

endmodule
